// File: rtl/fetch_queue_nway.sv
// -----------------------------------------------------------------------------
// fetch_queue_nway
//
// Instruction fetch queue between the ICache/BPU output and backend decode.
// Each cycle it accepts up to FETCH_W fetched slots under a sparse valid mask.
// The valid slots are packed, in ascending slot order, into a circular buffer.
// The buffer presents its ISSUE_W oldest entries on the output lanes. The
// backend accepts a leading prefix of those lanes.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   flush               drop all stored entries and this cycle's traffic
//   pause               hide output lanes (no dequeue); enqueue still allowed
//   in_valid            per-slot valid mask (FETCH_W)
//   in_inst/pc/...      per-slot payload, slot i in the i-th field of each bus
//   in_ready            room for a full FETCH_W group (registered count only)
//   out_valid           per-lane valid, lane 0 is the oldest entry
//   out_inst/pc/...     per-lane payload, zero on invalid lanes
//   out_ready           per-lane accept; only the leading accepted run counts
//   count               current occupancy
// -----------------------------------------------------------------------------
module fetch_queue_nway #(
    parameter int DEPTH   = 16,
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2,
    parameter int ECODE_W = 7
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         pause,

    input  logic [FETCH_W-1:0]           in_valid,
    input  logic [FETCH_W*32-1:0]        in_inst,
    input  logic [FETCH_W*32-1:0]        in_pc,
    input  logic [FETCH_W-1:0]           in_excp,
    input  logic [FETCH_W*ECODE_W-1:0]   in_ecode,
    input  logic [FETCH_W-1:0]           in_is_branch,
    input  logic [FETCH_W-1:0]           in_pre_taken,
    input  logic [FETCH_W*32-1:0]        in_pre_target,
    output logic                         in_ready,

    output logic [ISSUE_W-1:0]           out_valid,
    output logic [ISSUE_W*32-1:0]        out_inst,
    output logic [ISSUE_W*32-1:0]        out_pc,
    output logic [ISSUE_W*32-1:0]        out_pre_target,
    output logic [ISSUE_W-1:0]           out_excp,
    output logic [ISSUE_W-1:0]           out_is_branch,
    output logic [ISSUE_W-1:0]           out_pre_taken,
    output logic [ISSUE_W*ECODE_W-1:0]   out_ecode,
    input  logic [ISSUE_W-1:0]           out_ready,

    output logic [$clog2(DEPTH):0]       count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic [31:0]        inst;
        logic [31:0]        pc;
        logic [31:0]        pre_target;
        logic [ECODE_W-1:0] ecode;
        logic               excp;
        logic               is_branch;
        logic               pre_taken;
    } entry_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    entry_t mem [DEPTH];
    ptr_t   head;
    ptr_t   tail;

    // -------------------------------------------------------------------------
    // Input side: slot unpacking and compaction offsets
    // -------------------------------------------------------------------------
    entry_t in_entry [FETCH_W];
    cnt_t   slot_off [FETCH_W];
    cnt_t   n_enq;
    cnt_t   n_add;
    logic   enq_fire;

    always_comb begin
        for (int i = 0; i < FETCH_W; i++) begin
            in_entry[i].inst       = in_inst[32*i +: 32];
            in_entry[i].pc         = in_pc[32*i +: 32];
            in_entry[i].pre_target = in_pre_target[32*i +: 32];
            in_entry[i].ecode      = in_ecode[ECODE_W*i +: ECODE_W];
            in_entry[i].excp       = in_excp[i];
            in_entry[i].is_branch  = in_is_branch[i];
            in_entry[i].pre_taken  = in_pre_taken[i];
        end
    end

    // The offset of a slot is the number of valid slots below it. Invalid
    // slots therefore leave no hole in the buffer.
    // NOTE: every variable written in a combinational block gets a value before
    // any conditional update; otherwise a latch is inferred.
    always_comb begin
        n_enq = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            slot_off[i] = n_enq;
            if (in_valid[i]) begin
                n_enq = n_enq + 1'b1;
            end
        end
    end

    // Backpressure looks only at the registered occupancy. A dequeue in the
    // same cycle does not open room early, so in_ready has no path from out_ready.
    assign in_ready = (count <= cnt_t'(DEPTH - FETCH_W));
    assign enq_fire = in_ready && (|in_valid) && !flush;
    assign n_add    = enq_fire ? n_enq : '0;

    // -------------------------------------------------------------------------
    // Output lanes: combinational view of the oldest ISSUE_W entries
    // -------------------------------------------------------------------------
    entry_t lane_entry [ISSUE_W];

    always_comb begin
        for (int i = 0; i < ISSUE_W; i++) begin
            lane_entry[i] = mem[head + ptr_t'(i)];
        end
    end

    always_comb begin
        out_valid      = '0;
        out_inst       = '0;
        out_pc         = '0;
        out_pre_target = '0;
        out_excp       = '0;
        out_is_branch  = '0;
        out_pre_taken  = '0;
        out_ecode      = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            out_valid[i] = !pause && !flush && (cnt_t'(i) < count);
            // Invalid lanes drive zero payload. Stale buffer contents never
            // reach the backend.
            if (out_valid[i]) begin
                out_inst[32*i +: 32]             = lane_entry[i].inst;
                out_pc[32*i +: 32]               = lane_entry[i].pc;
                out_pre_target[32*i +: 32]       = lane_entry[i].pre_target;
                out_ecode[ECODE_W*i +: ECODE_W]  = lane_entry[i].ecode;
                out_excp[i]                      = lane_entry[i].excp;
                out_is_branch[i]                 = lane_entry[i].is_branch;
                out_pre_taken[i]                 = lane_entry[i].pre_taken;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Dequeue: length of the leading run of valid & ready lanes
    // -------------------------------------------------------------------------
    cnt_t deq_k;
    logic deq_run;

    // A gap ends the run. Ready bits on later lanes are ignored, so the
    // backend can only take entries in order. A flush or pause clears
    // out_valid, which forces deq_k to 0.
    always_comb begin
        deq_k   = '0;
        deq_run = 1'b1;
        for (int i = 0; i < ISSUE_W; i++) begin
            deq_run = deq_run && out_valid[i] && out_ready[i];
            if (deq_run) begin
                deq_k = deq_k + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Storage write
    // -------------------------------------------------------------------------
    // NOTE: the entry array has no reset. head, tail and count alone decide
    // what is live, so resetting the RAM would only cost area and reset fan-out.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            for (int i = 0; i < FETCH_W; i++) begin
                if (in_valid[i]) begin
                    mem[tail + ptr_t'(slot_off[i])] <= in_entry[i];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Pointers and occupancy
    // -------------------------------------------------------------------------
    // Pointers are exactly PTR_W bits wide, so the adds wrap modulo DEPTH.
    // count is one bit wider, which separates full from empty.
    // NOTE: registered state uses non-blocking assignments. Every flop then
    // samples pre-edge values, whatever order the blocks are evaluated in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + ptr_t'(deq_k);
            tail  <= tail + ptr_t'(n_add);
            count <= count + n_add - deq_k;
        end
    end

endmodule

// File: tb/tb_fetch_queue_nway.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue_nway
//
// Scoreboard bench for fetch_queue_nway with DEPTH=8, FETCH_W=2, ISSUE_W=2.
// Accepted slots are pushed to an expected queue when they are driven.
// Before each clock edge, every output lane, count and in_ready are compared
// against the head of that queue. Entries are popped as the bench's own
// prefix-accept rule dequeues them.
// -----------------------------------------------------------------------------
module tb_fetch_queue_nway;

    localparam int DEPTH = 8;
    localparam int FW    = 2;
    localparam int IW    = 2;
    localparam int EW    = 7;

    typedef struct packed {
        logic [31:0]   inst;
        logic [31:0]   pc;
        logic [31:0]   target;
        logic [EW-1:0] ecode;
        logic          excp;
        logic          br;
        logic          tk;
    } entry_t;

    logic               clk;
    logic               rst;
    logic               flush;
    logic               pause;
    logic [FW-1:0]      in_valid;
    logic [FW*32-1:0]   in_inst;
    logic [FW*32-1:0]   in_pc;
    logic [FW-1:0]      in_excp;
    logic [FW*EW-1:0]   in_ecode;
    logic [FW-1:0]      in_is_branch;
    logic [FW-1:0]      in_pre_taken;
    logic [FW*32-1:0]   in_pre_target;
    logic               in_ready;
    logic [IW-1:0]      out_valid;
    logic [IW*32-1:0]   out_inst;
    logic [IW*32-1:0]   out_pc;
    logic [IW*32-1:0]   out_pre_target;
    logic [IW-1:0]      out_excp;
    logic [IW-1:0]      out_is_branch;
    logic [IW-1:0]      out_pre_taken;
    logic [IW*EW-1:0]   out_ecode;
    logic [IW-1:0]      out_ready;
    logic [$clog2(DEPTH):0] count;

    fetch_queue_nway #(
        .DEPTH   (DEPTH),
        .FETCH_W (FW),
        .ISSUE_W (IW),
        .ECODE_W (EW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .pause          (pause),
        .in_valid       (in_valid),
        .in_inst        (in_inst),
        .in_pc          (in_pc),
        .in_excp        (in_excp),
        .in_ecode       (in_ecode),
        .in_is_branch   (in_is_branch),
        .in_pre_taken   (in_pre_taken),
        .in_pre_target  (in_pre_target),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_pre_target (out_pre_target),
        .out_excp       (out_excp),
        .out_is_branch  (out_is_branch),
        .out_pre_taken  (out_pre_taken),
        .out_ecode      (out_ecode),
        .out_ready      (out_ready),
        .count          (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    entry_t      exp_q[$];
    logic [31:0] pc_ctr = 32'h0;
    logic        ovr_excp = 1'b0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] lane_obs(input int i);
        entry_t e;
        e.inst   = out_inst[32*i +: 32];
        e.pc     = out_pc[32*i +: 32];
        e.target = out_pre_target[32*i +: 32];
        e.ecode  = out_ecode[EW*i +: EW];
        e.excp   = out_excp[i];
        e.br     = out_is_branch[i];
        e.tk     = out_pre_taken[i];
        return 128'(e);
    endfunction

    // Compare every output against the scoreboard. Inputs must be settled.
    task automatic check_outputs(input logic p, input logic f);
        logic         exp_v;
        logic [127:0] exp_pay;
        for (int i = 0; i < IW; i++) begin
            exp_v   = !p && !f && (i < exp_q.size());
            exp_pay = '0;
            if (exp_v) exp_pay = 128'(exp_q[i]);
            check($sformatf("lane%0d_valid", i), 128'(out_valid[i]), 128'(exp_v));
            check($sformatf("lane%0d_payload", i), lane_obs(i), exp_pay);
        end
        check("count", 128'(count), 128'(exp_q.size()));
        check("in_ready", 128'(in_ready), 128'((DEPTH - exp_q.size()) >= FW));
    endtask

    // One clock cycle, starting and ending at a falling edge.
    task automatic step(input logic [FW-1:0] v, input logic [IW-1:0] rdy,
                        input logic p, input logic f);
        entry_t slot [FW];
        int     k;
        bit     run;
        bit     acc;
        for (int s = 0; s < FW; s++) begin
            slot[s].pc     = pc_ctr;
            pc_ctr         = pc_ctr + 32'd4;
            slot[s].inst   = $urandom;
            slot[s].target = $urandom;
            slot[s].ecode  = EW'($urandom);
            slot[s].excp   = 1'($urandom_range(0, 1));
            slot[s].br     = 1'($urandom_range(0, 1));
            slot[s].tk     = 1'($urandom_range(0, 1));
            if (ovr_excp && s == 1) begin
                slot[s].excp  = 1'b1;
                slot[s].ecode = 7'h08;
            end
            in_inst[32*s +: 32]       = slot[s].inst;
            in_pc[32*s +: 32]         = slot[s].pc;
            in_pre_target[32*s +: 32] = slot[s].target;
            in_ecode[EW*s +: EW]      = slot[s].ecode;
            in_excp[s]                = slot[s].excp;
            in_is_branch[s]           = slot[s].br;
            in_pre_taken[s]           = slot[s].tk;
        end
        in_valid  = v;
        out_ready = rdy;
        pause     = p;
        flush     = f;
        #1;
        check_outputs(p, f);
        // Expected dequeue: leading run of visible, ready lanes.
        k   = 0;
        run = 1'b1;
        for (int i = 0; i < IW; i++) begin
            run = run && !p && !f && (i < exp_q.size()) && rdy[i];
            if (run) k++;
        end
        acc = ((DEPTH - exp_q.size()) >= FW) && (v != '0) && !f;
        @(posedge clk);
        if (f) begin
            exp_q.delete();
        end else begin
            repeat (k) void'(exp_q.pop_front());
            if (acc) begin
                for (int s = 0; s < FW; s++) begin
                    if (v[s]) exp_q.push_back(slot[s]);
                end
            end
        end
        @(negedge clk);
        in_valid  = '0;
        out_ready = '0;
        pause     = 1'b0;
        flush     = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst           = 1'b1;
        flush         = 1'b0;
        pause         = 1'b0;
        in_valid      = '0;
        in_inst       = '0;
        in_pc         = '0;
        in_excp       = '0;
        in_ecode      = '0;
        in_is_branch  = '0;
        in_pre_taken  = '0;
        in_pre_target = '0;
        out_ready     = '0;

        // Reset state, seen before any clock edge.
        #1;
        check("rst_count", 128'(count), 128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_out_pc", 128'(out_pc), 128'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Full group, both lanes visible the next cycle.
        pc_ctr = 32'h1c00_0000;
        step(2'b11, 2'b00, 1'b0, 1'b0);
        check("tp1_valid", 128'(out_valid), 128'(2'b11));
        check("tp1_pc0", 128'(out_pc[31:0]), 128'(32'h1c00_0000));
        check("tp1_pc1", 128'(out_pc[63:32]), 128'(32'h1c00_0004));
        check("tp1_count", 128'(count), 128'(2));
        step(2'b00, 2'b11, 1'b0, 1'b0);

        // Sparse mask: slot 1 only, lands in lane 0.
        pc_ctr   = 32'h1c00_0100;
        ovr_excp = 1'b1;
        step(2'b10, 2'b00, 1'b0, 1'b0);
        ovr_excp = 1'b0;
        check("tp2_valid", 128'(out_valid), 128'(2'b01));
        check("tp2_pc0", 128'(out_pc[31:0]), 128'(32'h1c00_0104));
        check("tp2_excp0", 128'(out_excp[0]), 128'(1));
        check("tp2_ecode0", 128'(out_ecode[EW-1:0]), 128'(7'h08));
        check("tp2_count", 128'(count), 128'(1));
        step(2'b00, 2'b01, 1'b0, 1'b0);

        // Fill to full, then an ignored fifth offer.
        repeat (4) step(2'b11, 2'b00, 1'b0, 1'b0);
        check("full_count", 128'(count), 128'(8));
        check("full_in_ready", 128'(in_ready), 128'(0));
        step(2'b11, 2'b00, 1'b0, 1'b0);
        check("full_hold_count", 128'(count), 128'(8));

        // Drain to two entries.
        repeat (3) step(2'b00, 2'b11, 1'b0, 1'b0);
        check("drain_count", 128'(count), 128'(2));

        // Gap in ready: no dequeue.
        step(2'b00, 2'b10, 1'b0, 1'b0);
        check("gap_count", 128'(count), 128'(2));
        // Single-lane accept.
        step(2'b00, 2'b01, 1'b0, 1'b0);
        check("k1_count", 128'(count), 128'(1));
        // Pause blocks dequeue.
        step(2'b00, 2'b11, 1'b1, 1'b0);
        check("pause_count", 128'(count), 128'(1));

        // Build up to six entries, then run in steady state through the wrap.
        step(2'b11, 2'b00, 1'b0, 1'b0);
        step(2'b11, 2'b00, 1'b0, 1'b0);
        step(2'b01, 2'b00, 1'b0, 1'b0);
        check("pre_stream_count", 128'(count), 128'(6));
        repeat (12) step(2'b11, 2'b11, 1'b0, 1'b0);
        check("stream_count", 128'(count), 128'(6));

        // Flush at five entries with a simultaneous enqueue and dequeue offer.
        step(2'b00, 2'b01, 1'b0, 1'b0);
        check("pre_flush_count", 128'(count), 128'(5));
        step(2'b11, 2'b11, 1'b0, 1'b1);
        check("flush_count", 128'(count), 128'(0));
        check("flush_out_valid", 128'(out_valid), 128'(0));
        check("flush_in_ready", 128'(in_ready), 128'(1));

        // Refill, then an asynchronous reset between clock edges.
        step(2'b11, 2'b00, 1'b0, 1'b0);
        step(2'b11, 2'b00, 1'b0, 1'b0);
        check("pre_rst_count", 128'(count), 128'(4));
        rst = 1'b1;
        #1;
        check("arst_count", 128'(count), 128'(0));
        check("arst_out_valid", 128'(out_valid), 128'(0));
        check("arst_in_ready", 128'(in_ready), 128'(1));
        check("arst_out_pc", 128'(out_pc), 128'(0));
        exp_q.delete();
        #2;
        rst = 1'b0;
        @(negedge clk);

        // Queue works again after reset.
        step(2'b01, 2'b00, 1'b0, 1'b0);
        step(2'b00, 2'b01, 1'b0, 1'b0);
        step(2'b00, 2'b00, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
